// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM state encoding
// and the writeback-select (mem_to_reg) codes.
package mem_access_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;

endpackage

// File: rtl/mem_access_stage_reg_mem_wb.sv
// MEM/WB pipeline register. Loads every edge; a bubble clears the writeback
// enable so the slot retires as a no-op.
module reg_mem_wb (
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic [31:0] wb_data_d,
  input  logic [4:0]  write_reg_d,
  input  logic        reg_write_d,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_write_reg,
  output logic        o_reg_write
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_wb_data   <= '0;
      o_write_reg <= '0;
      o_reg_write <= 1'b0;
    end else begin
      o_wb_data   <= wb_data_d;
      o_write_reg <= write_reg_d;
      o_reg_write <= reg_write_d & ~bubble;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: two-state memory access FSM, data-memory interface and
// MEM/WB register. Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_mem_wr_data,
  input  logic [4:0]  i_write_reg,
  input  logic        i_reg_write,
  input  logic [1:0]  i_mem_to_reg,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  output logic        o_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_write_reg,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        o_mem_fault,
`endif
  output logic        o_reg_write
);

  state_t      state, state_nxt;
  logic        mem_op;
  logic        misaligned;
  logic        bubble;
  logic        sel_mem;
  logic [31:0] wb_data_d;

  assign mem_op = i_mem_read | i_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = mem_op & (i_alu_result[1:0] != 2'b00);

  // Fault is a registered one-cycle pulse following the trapped op's edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) o_mem_fault <= 1'b0;
    else        o_mem_fault <= (state == IDLE) & misaligned;
  end
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_stall    = 1'b0;
    bubble     = 1'b0;
    sel_mem    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          bubble = 1'b1;
          if (!misaligned) begin
            o_stall   = 1'b1;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        // Inputs are held upstream while stalled, so driving straight from
        // them keeps the request stable without an internal copy.
        dmem_req   = 1'b1;
        dmem_we    = i_mem_write;
        dmem_addr  = i_alu_result;
        dmem_wdata = i_mem_wr_data;
        if (dmem_ack) begin
          state_nxt = IDLE;
          sel_mem   = (i_mem_to_reg == WB_MEM) & i_mem_read;
        end else begin
          o_stall = 1'b1;
          bubble  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wb_data_d = sel_mem ? dmem_rdata : i_alu_result;

  reg_mem_wb u_reg_mem_wb (
    .clk         (clk),
    .reset       (reset),
    .bubble      (bubble),
    .wb_data_d   (wb_data_d),
    .write_reg_d (i_write_reg),
    .reg_write_d (i_reg_write),
    .o_wb_data   (o_wb_data),
    .o_write_reg (o_write_reg),
    .o_reg_write (o_reg_write)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage (build with or without
// MEM_MISALIGN_TRAP_EN).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_alu_result;
  logic [31:0] i_mem_wr_data;
  logic [4:0]  i_write_reg;
  logic        i_reg_write;
  logic [1:0]  i_mem_to_reg;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        o_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] o_wb_data;
  logic [4:0]  o_write_reg;
  logic        o_reg_write;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        o_mem_fault;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_exp_t;

  wb_exp_t sb[$];
  wb_exp_t mon_e;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk           (clk),
    .reset         (reset),
    .i_alu_result  (i_alu_result),
    .i_mem_wr_data (i_mem_wr_data),
    .i_write_reg   (i_write_reg),
    .i_reg_write   (i_reg_write),
    .i_mem_to_reg  (i_mem_to_reg),
    .i_mem_read    (i_mem_read),
    .i_mem_write   (i_mem_write),
    .o_stall       (o_stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .o_wb_data     (o_wb_data),
    .o_write_reg   (o_write_reg),
`ifdef MEM_MISALIGN_TRAP_EN
    .o_mem_fault   (o_mem_fault),
`endif
    .o_reg_write   (o_reg_write)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Every retired writeback must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && o_reg_write === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_wb", 32'(o_reg_write), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("wb_data", o_wb_data, mon_e.data);
        check_eq("wb_reg", 32'(o_write_reg), 32'(mon_e.rd));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop;
    i_alu_result  = '0;
    i_mem_wr_data = '0;
    i_write_reg   = '0;
    i_reg_write   = 1'b0;
    i_mem_to_reg  = 2'b00;
    i_mem_read    = 1'b0;
    i_mem_write   = 1'b0;
    dmem_ack      = 1'b0;
  endtask

  task automatic alu_op(input logic [31:0] res, input logic [1:0] m2r,
                        input logic [4:0] rd, input logic rw);
    i_alu_result = res;
    i_mem_to_reg = m2r;
    i_write_reg  = rd;
    i_reg_write  = rw;
    i_mem_read   = 1'b0;
    i_mem_write  = 1'b0;
    if (rw) sb.push_back('{data: res, rd: rd});
    #1;
    check_eq("alu_stall", 32'(o_stall), 32'd0);
    check_eq("alu_req", 32'(dmem_req), 32'd0);
    tick;
    check_eq("alu_wb_en", 32'(o_reg_write), 32'(rw));
  endtask

  task automatic mem_op(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic rd_en, input logic wr_en,
                        input logic [1:0] m2r, input logic [4:0] rd, input logic rw,
                        input int unsigned wait_n,
                        output int unsigned stall_cnt, output int unsigned req_wait_cnt);
    logic [31:0] exp_data;
    stall_cnt     = 0;
    req_wait_cnt  = 0;
    i_alu_result  = addr;
    i_mem_wr_data = wdata;
    i_mem_read    = rd_en;
    i_mem_write   = wr_en;
    i_mem_to_reg  = m2r;
    i_write_reg   = rd;
    i_reg_write   = rw;
    dmem_ack      = 1'b0;
    dmem_rdata    = rdata;
    exp_data = (m2r == 2'b01 && rd_en) ? rdata : addr;
    if (rw) sb.push_back('{data: exp_data, rd: rd});
    #1;
    check_eq("idle_stall", 32'(o_stall), 32'd1);
    check_eq("idle_req", 32'(dmem_req), 32'd0);
    if (o_stall) stall_cnt++;
    for (int i = 0; i <= int'(wait_n); i++) begin
      tick;
      dmem_ack = (i == int'(wait_n));
      #1;
      check_eq("busy_req", 32'(dmem_req), 32'd1);
      check_eq("busy_addr", dmem_addr, addr);
      check_eq("busy_we", 32'(dmem_we), 32'(wr_en));
      check_eq("busy_wdata", dmem_wdata, wdata);
      check_eq("busy_stall", 32'(o_stall), 32'(i != int'(wait_n)));
      if (!rw) check_eq("busy_no_wb", 32'(o_reg_write), 32'd0);
      if (o_stall) stall_cnt++;
      if (dmem_req && !dmem_ack) req_wait_cnt++;
    end
    tick;
    dmem_ack = 1'b0;
    check_eq("done_req", 32'(dmem_req), 32'd0);
    check_eq("wb_2nd_edge", 32'(o_reg_write), 32'(rw));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned sc, rc;
    reset = 1'b0;
    drive_nop();
    dmem_rdata = '0;
    #12;
    check_eq("rst_reg_write", 32'(o_reg_write), 32'd0);
    check_eq("rst_wb_data", o_wb_data, 32'd0);
    check_eq("rst_write_reg", 32'(o_write_reg), 32'd0);
    check_eq("rst_req", 32'(dmem_req), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    check_eq("rst_fault", 32'(o_mem_fault), 32'd0);
`endif
    @(negedge clk);
    #2 reset = 1'b1;
    tick;

    // ALU ops, including non-ALU select codes that must still return the ALU result
    alu_op(32'h0000_1234, 2'b00, 5'd5, 1'b1);
    alu_op(32'hCAFE_0001, 2'b01, 5'd9, 1'b1);
    alu_op(32'h0000_7777, 2'b00, 5'd2, 1'b0);
    drive_nop();

    // Load, ack three cycles after the request rises
    mem_op(32'h100, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'b01, 5'd8, 1'b1, 3, sc, rc);
    check_eq("load_stall_cycles", sc, 32'd4);
    check_eq("load_req_wait", rc, 32'd3);
    drive_nop();

    // Store, acked in the first BUSY cycle
    mem_op(32'h200, 32'h55, 32'h1111_2222, 1'b0, 1'b1, 2'b00, 5'd0, 1'b0, 0, sc, rc);
    check_eq("store_stall_cycles", sc, 32'd1);

    // Read+write together behaves as a store
    mem_op(32'h204, 32'hA5A5_0F0F, 32'h3333_4444, 1'b1, 1'b1, 2'b01, 5'd0, 1'b0, 1, sc, rc);

    // Load with select 10 writes back the address, not the read data
    mem_op(32'h208, 32'h0, 32'h9999_8888, 1'b1, 1'b0, 2'b10, 5'd11, 1'b1, 0, sc, rc);

    // Back-to-back loads acked immediately
    mem_op(32'h300, 32'h0, 32'h0102_0304, 1'b1, 1'b0, 2'b01, 5'd12, 1'b1, 0, sc, rc);
    mem_op(32'h304, 32'h0, 32'hA0B0_C0D0, 1'b1, 1'b0, 2'b01, 5'd13, 1'b1, 0, sc, rc);
    mem_op(32'h308, 32'h0, 32'h5555_AAAA, 1'b1, 1'b0, 2'b01, 5'd14, 1'b1, 0, sc, rc);
    drive_nop();

`ifdef MEM_MISALIGN_TRAP_EN
    i_alu_result = 32'h102;
    i_mem_read   = 1'b1;
    i_mem_to_reg = 2'b01;
    i_write_reg  = 5'd3;
    i_reg_write  = 1'b1;
    #1;
    check_eq("mis_stall", 32'(o_stall), 32'd0);
    check_eq("mis_req", 32'(dmem_req), 32'd0);
    tick;
    drive_nop();
    check_eq("mis_fault", 32'(o_mem_fault), 32'd1);
    check_eq("mis_wb_en", 32'(o_reg_write), 32'd0);
    check_eq("mis_req_after", 32'(dmem_req), 32'd0);
    tick;
    check_eq("mis_fault_clear", 32'(o_mem_fault), 32'd0);
`else
    mem_op(32'h102, 32'h0, 32'h7E7E_7E7E, 1'b1, 1'b0, 2'b01, 5'd3, 1'b1, 0, sc, rc);
    drive_nop();
`endif

    // Reset mid-BUSY abandons the access
    i_alu_result = 32'h400;
    i_mem_read   = 1'b1;
    i_mem_to_reg = 2'b01;
    i_write_reg  = 5'd7;
    i_reg_write  = 1'b1;
    tick;
    check_eq("pre_rst_req", 32'(dmem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_busy_req", 32'(dmem_req), 32'd0);
    check_eq("rst_busy_wb", 32'(o_reg_write), 32'd0);
    drive_nop();
    @(negedge clk);
    #2 reset = 1'b1;
    tick;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_0000;
    #1;
    check_eq("stray_ack_stall", 32'(o_stall), 32'd0);
    check_eq("stray_ack_req", 32'(dmem_req), 32'd0);
    tick;
    dmem_ack = 1'b0;
    check_eq("stray_ack_wb", 32'(o_reg_write), 32'd0);
    check_eq("stray_ack_idle", 32'(dmem_req), 32'd0);

    // An ack arriving with a new op in IDLE must not complete it
    i_alu_result = 32'h500;
    i_mem_read   = 1'b1;
    i_mem_to_reg = 2'b01;
    i_write_reg  = 5'd21;
    i_reg_write  = 1'b1;
    dmem_rdata   = 32'h0BAD_F00D;
    dmem_ack     = 1'b1;
    sb.push_back('{data: 32'h0BAD_F00D, rd: 5'd21});
    #1;
    check_eq("idle_ack_stall", 32'(o_stall), 32'd1);
    tick;
    check_eq("idle_ack_busy", 32'(dmem_req), 32'd1);
    check_eq("idle_ack_stall2", 32'(o_stall), 32'd0);
    tick;
    drive_nop();
    check_eq("idle_ack_wb", 32'(o_reg_write), 32'd1);

    repeat (3) tick;
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
